// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings, SRAM slave FSM states and byte-enable helper
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  // Lanes touched by a transfer; caller truncates to its word width.
  function automatic logic [15:0] be_mask(input logic [2:0] hsize, input logic [2:0] low);
    logic [15:0] lanes;
    case (hsize)
      3'd0:    lanes = 16'h0001;
      3'd1:    lanes = 16'h0003;
      3'd2:    lanes = 16'h000F;
      default: lanes = 16'h00FF;
    endcase
    return lanes << low;
  endfunction

endpackage

// File: rtl/ahb_sram_ws_if.sv
// rtl/ahb_sram_ws_if.sv - AHB-Lite slave bus bundle with master/slave modports
interface ahb_sram_ws_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/sram_byte_bank.sv
// rtl/sram_byte_bank.sv - DEPTH x DATA_WIDTH array, per-byte write enables, registered read
module sram_byte_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8192,
  parameter int IDX_W      = 13,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    re,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (we[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sram_ws.sv
// rtl/ahb_sram_ws.sv - AHB-Lite SRAM slave with wait states, two-cycle ERROR and write forwarding
// AHB_SRAM_ALIGN_CHECK_EN: when defined, misaligned transfers get an ERROR response.
module ahb_sram_ws
  import ahb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH       = 8192,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter                        INIT_FILE   = ""
) (
  input logic          HCLK,
  input logic          HRESET,
  ahb_sram_ws_if.slave bus
);
  localparam int          BYTES = DATA_WIDTH / 8;
  localparam int          LB    = $clog2(BYTES);
  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'(BYTES);
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      a_idx;
  logic [BYTES-1:0]      a_mask;
  logic                  a_err, a_sel, size_err, range_err, align_err;

  sram_state_e           state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [IDX_W-1:0]      widx_q, widx_d;
  logic [BYTES-1:0]      wmask_q, wmask_d;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [BYTES-1:0]      fwd_mask_q, fwd_mask_d;

  logic                  hreadyout, hresp, take, commit, rd_en;
  logic [DATA_WIDTH-1:0] bank_rdata;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign off       = bus.HADDR - BASE_ADDR;
  assign a_idx     = off[LB +: IDX_W];
  assign a_mask    = BYTES'(be_mask(bus.HSIZE, 3'(bus.HADDR[LB-1:0])));
  assign size_err  = bus.HSIZE > 3'(LB);
  assign range_err = 64'(off) >= SPAN;
`ifdef AHB_SRAM_ALIGN_CHECK_EN
  assign align_err = |(bus.HADDR[LB-1:0] & ((LB'(1) << bus.HSIZE) - LB'(1)));
`else
  assign align_err = 1'b0;
`endif
  assign a_err = size_err | range_err | align_err;
  assign a_sel = bus.HSEL & bus.HREADY &
                 ((bus.HTRANS == HTRANS_NONSEQ) | (bus.HTRANS == HTRANS_SEQ));

  always_comb begin
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_pend_d  = wr_pend_q;
    widx_d     = widx_q;
    wmask_d    = wmask_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    fwd_mask_d = fwd_mask_q;

    case (state_q)
      ST_WAIT: hreadyout = (cnt_q == WS);
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase

    take   = a_sel & hreadyout;
    commit = wr_pend_q & hreadyout & bus.HREADY;
    rd_en  = take & ~bus.HWRITE & ~a_err;

    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (hreadyout & bus.HREADY) begin
      if (take & a_err) begin
        state_d = ST_ERR1;
      end else if (take && WAIT_STATES != 0) begin
        state_d = ST_WAIT;
        cnt_d   = 3'd0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_WAIT && cnt_q != WS) begin
      cnt_d = cnt_q + 3'd1;
    end

    if (commit) wr_pend_d = 1'b0;
    if (take) begin
      widx_d  = a_idx;
      wmask_d = a_mask;
      if (bus.HWRITE & ~a_err) wr_pend_d = 1'b1;
    end

    // A read landing on the word being committed this edge sees the new lanes.
    if (rd_en) begin
      fwd_d      = commit & (widx_q == a_idx);
      fwd_data_d = bus.HWDATA;
      fwd_mask_d = wmask_q;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      wr_pend_q  <= 1'b0;
      widx_q     <= '0;
      wmask_q    <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pend_q  <= wr_pend_d;
      widx_q     <= widx_d;
      wmask_q    <= wmask_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      fwd_mask_q <= fwd_mask_d;
    end
  end

  sram_byte_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk  (HCLK),
    .rst  (HRESET),
    .re   (rd_en),
    .raddr(a_idx),
    .rdata(bank_rdata),
    .we   (commit ? wmask_q : '0),
    .waddr(widx_q),
    .wdata(bus.HWDATA)
  );

  always_comb begin
    bus.HRDATA = bank_rdata;
    for (int i = 0; i < BYTES; i++) begin
      if (fwd_q & fwd_mask_q[i]) bus.HRDATA[i*8 +: 8] = fwd_data_q[i*8 +: 8];
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;

endmodule

// File: tb/tb_ahb_sram_ws.sv
// tb/tb_ahb_sram_ws.sv - self-checking bench: zero-wait and two-wait slaves against a word-array model
module tb_ahb_sram_ws;
  import ahb_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE1 = 32'h0000_2000;
  localparam int          WS1   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_sram_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b0 ();
  ahb_sram_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();

  ahb_sram_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0),
                .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (.HCLK(clk), .HRESET(rst), .bus(b0));
  ahb_sram_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE1),
                .WAIT_STATES(WS1), .INIT_FILE("")) u_ws2 (.HCLK(clk), .HRESET(rst), .bus(b1));

  int          dsel;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  assign b0.HSEL   = hsel && (dsel == 0);
  assign b1.HSEL   = hsel && (dsel == 1);
  assign b0.HADDR  = haddr;   assign b1.HADDR  = haddr;
  assign b0.HTRANS = htrans;  assign b1.HTRANS = htrans;
  assign b0.HWRITE = hwrite;  assign b1.HWRITE = hwrite;
  assign b0.HSIZE  = hsize;   assign b1.HSIZE  = hsize;
  assign b0.HWDATA = hwdata;  assign b1.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT;
  assign b1.HREADY = b1.HREADYOUT;

  int          vectors, miscompares;
  logic [31:0] mdl [2][DEPTH];
  logic [31:0] last_rd [2];
  logic [31:0] last_obs;

  logic [31:0] op_addr [64];
  logic [31:0] op_data [64];
  bit          op_wr   [64];
  logic [2:0]  op_size [64];
  int          nops;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : BASE1;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : WS1;
  endfunction

  function automatic bit exp_err(input int d, input logic [31:0] a, input logic [2:0] s);
    logic [31:0] o;
    o = a - base_of(d);
    return (o >= 32'(DEPTH * 4)) || (s > 3'd2);
  endfunction

  task automatic add_op(input logic [31:0] a, input bit wr, input logic [2:0] s, input logic [31:0] dat);
    op_addr[nops] = a; op_wr[nops] = wr; op_size[nops] = s; op_data[nops] = dat;
    nops++;
  endtask

  task automatic complete(input int d, input int k, input int lowc, input bit bad,
                          input bit rsp, input logic [31:0] rd);
    bit          e;
    int          idx, lo, n;
    logic [31:0] exp_rd;
    e = exp_err(d, op_addr[k], op_size[k]);
    chk("wait_cycles", 32'(lowc), 32'(e ? 1 : ws_of(d)));
    chk("hresp_final", {31'd0, rsp}, {31'd0, e});
    chk("hresp_stable", {31'd0, bad}, 32'd0);
    idx = int'((op_addr[k] - base_of(d)) >> 2);
    lo  = int'(op_addr[k][1:0]);
    n   = 1 << op_size[k];
    if (!e && op_wr[k]) begin
      for (int b = 0; b < 4; b++)
        if (b >= lo && b < lo + n) mdl[d][idx][b*8 +: 8] = op_data[k][b*8 +: 8];
    end
    if (!op_wr[k]) begin
      exp_rd = e ? last_rd[d] : mdl[d][idx];
      chk("hrdata", rd, exp_rd);
      last_rd[d] = exp_rd;
      last_obs   = rd;
    end
  endtask

  task automatic drive_addr(input int ap);
    if (ap < nops) begin
      hsel   = 1'b1;
      htrans = ap[0] ? HTRANS_SEQ : HTRANS_NONSEQ;
      haddr  = op_addr[ap];
      hwrite = op_wr[ap];
      hsize  = op_size[ap];
    end else begin
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
    end
  endtask

  // Issues the queued ops back to back on one slave, checking each at its last data-phase cycle.
  task automatic run(input int d);
    int          ap, dp, lowc, guard;
    bit          bad, rdy, rsp;
    logic [31:0] rd;
    dsel = d; ap = 0; dp = -1; lowc = 0; bad = 0; guard = 0;
    drive_addr(0);
    while ((ap < nops || dp >= 0) && guard < 4000) begin
      @(negedge clk);
      rdy = (d == 0) ? b0.HREADYOUT : b1.HREADYOUT;
      rsp = (d == 0) ? b0.HRESP     : b1.HRESP;
      rd  = (d == 0) ? b0.HRDATA    : b1.HRDATA;
      if (dp >= 0) begin
        if (!rdy) lowc++;
        if (rsp !== exp_err(d, op_addr[dp], op_size[dp])) bad = 1'b1;
        if (rdy) complete(d, dp, lowc, bad, rsp, rd);
      end
      @(posedge clk); #1;
      if (rdy) begin
        dp = (ap < nops) ? ap : -1;
        if (ap < nops) ap++;
        lowc = 0; bad = 1'b0;
        hwdata = (dp >= 0) ? op_data[dp] : 32'h0;
        drive_addr(ap);
      end
      guard++;
    end
    chk("run_drained", 32'((nops - ap) + ((dp >= 0) ? 1 : 0)), 32'd0);
    nops = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; nops = 0; dsel = 0; last_obs = '0;
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hreadyout0", 32'(b0.HREADYOUT), 32'd1);
    chk("rst_hresp0",     32'(b0.HRESP),     32'd0);
    chk("rst_hrdata0",    b0.HRDATA,         32'd0);
    chk("rst_hreadyout1", 32'(b1.HREADYOUT), 32'd1);
    chk("rst_hrdata1",    b1.HRDATA,         32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // BUSY and IDLE on an out-of-range address must not start an error
    dsel = 0; hsel = 1'b1; haddr = 32'(DEPTH * 4); hsize = HSIZE_WORD;
    htrans = HTRANS_BUSY;
    @(posedge clk); #1;
    chk("busy_ready", 32'(b0.HREADYOUT), 32'd1);
    chk("busy_resp",  32'(b0.HRESP),     32'd0);
    htrans = HTRANS_IDLE;
    @(posedge clk); #1;
    chk("idle_ready", 32'(b0.HREADYOUT), 32'd1);
    hsel = 1'b0;

    // Fill both arrays so every later read has a known expectation
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < DEPTH / 64; c++) begin
        for (int i = 0; i < 64; i++)
          add_op(base_of(d) + 32'((c * 64 + i) * 4), 1'b1, HSIZE_WORD, $urandom);
        run(d);
      end
    end

    add_op(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
    add_op(32'h10, 1'b0, HSIZE_WORD, 32'h0);
    run(0);
    chk("word_rw_lit", last_obs, 32'hDEADBEEF);

    add_op(BASE1, 1'b0, HSIZE_WORD, 32'h0);
    run(1);

    add_op(32'h10, 1'b1, HSIZE_WORD, 32'h11223344);
    add_op(32'h13, 1'b1, HSIZE_BYTE, 32'hAA000000);
    add_op(32'h10, 1'b0, HSIZE_WORD, 32'h0);
    run(0);
    chk("fwd_byte_lit", last_obs, 32'hAA223344);

    add_op(BASE1 + 32'h10, 1'b1, HSIZE_WORD, 32'h11223344);
    add_op(BASE1 + 32'h13, 1'b1, HSIZE_BYTE, 32'hAA000000);
    add_op(BASE1 + 32'h10, 1'b0, HSIZE_WORD, 32'h0);
    run(1);
    chk("fwd_byte_ws_lit", last_obs, 32'hAA223344);

    add_op(32'(DEPTH * 4), 1'b0, HSIZE_WORD, 32'h0);
    add_op(32'(DEPTH * 4), 1'b1, HSIZE_WORD, 32'hFFFFFFFF);
    add_op(32'h20, 1'b1, HSIZE_DWORD, 32'hFFFFFFFF);
    add_op(32'h0, 1'b0, HSIZE_WORD, 32'h0);
    add_op(32'h20, 1'b0, HSIZE_WORD, 32'h0);
    run(0);

    add_op(BASE1 - 32'd4, 1'b0, HSIZE_WORD, 32'h0);
    add_op(BASE1 - 32'd4, 1'b1, HSIZE_WORD, 32'hFFFFFFFF);
    add_op(BASE1 + 32'(DEPTH * 4), 1'b1, HSIZE_WORD, 32'hFFFFFFFF);
    add_op(BASE1 + 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    add_op(BASE1 + 32'hFC, 1'b0, HSIZE_WORD, 32'h0);
    run(1);

    add_op(32'h0, 1'b1, HSIZE_WORD, 32'h55667788);
    add_op(32'h1, 1'b1, HSIZE_HALF, 32'hA1B2C3D4);
    add_op(32'h0, 1'b0, HSIZE_WORD, 32'h0);
    run(0);
    chk("misaligned_half_lit", last_obs, 32'h55B2C388);

    // Reset in the second wait cycle of a write drops the write
    dsel = 1; hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
    haddr = BASE1 + 32'h40;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hCAFEF00D;
    chk("wait1_low", 32'(b1.HREADYOUT), 32'd0);
    @(posedge clk); #1;
    chk("wait2_low", 32'(b1.HREADYOUT), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(b1.HREADYOUT), 32'd1);
    chk("async_rst_resp",  32'(b1.HRESP),     32'd0);
    chk("async_rst_rdata", b1.HRDATA,         32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    add_op(BASE1 + 32'h40, 1'b0, HSIZE_WORD, 32'h0);
    run(1);

    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 3; r++) begin
        for (int i = 0; i < 48; i++)
          add_op(base_of(d) - 32'(d * 16) + 32'($urandom_range(0, DEPTH * 4 + 48)),
                 bit'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom);
        run(d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
